// File: rtl/hack_data_bus_responder.sv
// Hack CPU data-bus responder: data RAM plus a memory-mapped I/O page holding a
// one-entry keyboard buffer, an LED register and a prescaled free-running timer.
module hack_data_bus_responder #(
  parameter int RAM_ADDR_W = 14,
  parameter int TIMER_DIV  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] key_data,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [15:0] leds
);

  localparam int          RAM_DEPTH     = 1 << RAM_ADDR_W;
  localparam logic [16:0] RAM_LIMIT     = 17'(RAM_DEPTH);
  localparam logic [15:0] ADDR_KBD      = 16'h6000;
  localparam logic [15:0] ADDR_KBD_CLR  = 16'h6001;
  localparam logic [15:0] ADDR_LED      = 16'h6002;
  localparam logic [15:0] ADDR_TIMER    = 16'h6003;
  localparam logic [15:0] ADDR_TMR_CTRL = 16'h6004;
  localparam logic [15:0] PRESC_LAST    = 16'(TIMER_DIV - 1);

  typedef enum logic {
    KB_EMPTY = 1'b0,
    KB_FULL  = 1'b1
  } kb_state_e;

  logic [15:0] ram_q [RAM_DEPTH];

  kb_state_e   kb_state_q, kb_state_d;
  logic        key_ready_q, key_ready_d;
  logic [15:0] key_code_q, key_code_d;
  logic [15:0] leds_q, leds_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] presc_q, presc_d;
  logic        en_q, en_d;

  logic                  sel_ram;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  wr_ram;
  logic                  wr_kbd_clr;
  logic                  wr_led;
  logic                  wr_timer;
  logic                  wr_ctrl;

  // Full 16-bit compare so the gap between RAM and the I/O page never aliases.
  assign sel_ram    = ({1'b0, addressM} < RAM_LIMIT);
  assign ram_idx    = addressM[RAM_ADDR_W-1:0];
  assign wr_ram     = writeM && sel_ram;
  assign wr_kbd_clr = writeM && (addressM == ADDR_KBD_CLR);
  assign wr_led     = writeM && (addressM == ADDR_LED);
  assign wr_timer   = writeM && (addressM == ADDR_TIMER);
  assign wr_ctrl    = writeM && (addressM == ADDR_TMR_CTRL);

  always_comb begin
    inM = 16'h0000;
    if (sel_ram) begin
      inM = ram_q[ram_idx];
    end else begin
      case (addressM)
        ADDR_KBD:      inM = (kb_state_q == KB_FULL) ? key_code_q : 16'h0000;
        ADDR_LED:      inM = leds_q;
        ADDR_TIMER:    inM = timer_q;
        ADDR_TMR_CTRL: inM = {15'b0, en_q};
        default:       inM = 16'h0000;
      endcase
    end
  end

  // Keyboard buffer: in FULL the source is back-pressured, so a clear always wins.
  always_comb begin
    kb_state_d = kb_state_q;
    key_code_d = key_code_q;
    case (kb_state_q)
      KB_EMPTY: begin
        if (key_valid) begin
          kb_state_d = KB_FULL;
          key_code_d = key_data;
        end
      end
      KB_FULL: begin
        if (wr_kbd_clr) begin
          kb_state_d = KB_EMPTY;
        end
      end
      default: kb_state_d = KB_EMPTY;
    endcase
    key_ready_d = (kb_state_d == KB_EMPTY);
  end

  always_comb begin
    leds_d = wr_led ? outM : leds_q;
    en_d   = wr_ctrl ? outM[0] : en_q;
  end

  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q;
    if (wr_timer) begin
      timer_d = outM;
      presc_d = 16'h0000;
    end else if (en_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = 16'h0000;
        timer_d = timer_q + 16'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kb_state_q  <= KB_EMPTY;
      key_ready_q <= 1'b1;
      leds_q      <= 16'h0000;
      timer_q     <= 16'h0000;
      presc_q     <= 16'h0000;
      en_q        <= 1'b0;
    end else begin
      kb_state_q  <= kb_state_d;
      key_ready_q <= key_ready_d;
      leds_q      <= leds_d;
      timer_q     <= timer_d;
      presc_q     <= presc_d;
      en_q        <= en_d;
    end
  end

  // Data-only state: RAM and the latched key code are never reset.
  always_ff @(posedge clk) begin
    key_code_q <= key_code_d;
    if (!reset && wr_ram) begin
      ram_q[ram_idx] <= outM;
    end
  end

  assign key_ready = key_ready_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_hack_data_bus_responder.sv
// Directed bench for hack_data_bus_responder with TIMER_DIV=4.
module tb_hack_data_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] key_data;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  hack_data_bus_responder #(.RAM_ADDR_W(14), .TIMER_DIV(4)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] regs [4];
    regs[0] = 16'h6002; regs[1] = 16'h6003; regs[2] = 16'h6004; regs[3] = 16'h6000;
    reset = 1'b1; writeM = 1'b0; key_valid = 1'b0; addressM = 16'h0; outM = 16'h0; key_data = 16'h0;
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addressM = regs[i]; #1;
      n_checks++;
      if (inM !== 16'h0000) begin
        n_fail++; $display("FAIL reset_read addr=%h got=%h exp=0000", regs[i], inM);
      end
    end
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
    n_checks++;
    if (leds !== 16'h0000) begin n_fail++; $display("FAIL reset_leds got=%h exp=0000", leds); end
  endtask

  task automatic test_ram();
    addressM = 16'h0005; outM = 16'h1111; writeM = 1'b1;
    cyc();
    outM = 16'h1234; #1;
    n_checks++;
    if (inM !== 16'h1111) begin n_fail++; $display("FAIL ram_rdw_old got=%h exp=1111", inM); end
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h1234) begin n_fail++; $display("FAIL ram_read_new got=%h exp=1234", inM); end
    addressM = 16'h3FFF; outM = 16'hA5A5; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'hA5A5) begin n_fail++; $display("FAIL ram_top_word got=%h exp=a5a5", inM); end
    addressM = 16'h4000; outM = 16'hBEEF; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL gap_read_4000 got=%h exp=0000", inM); end
    addressM = 16'h0000; #1;
    n_checks++;
    if (inM === 16'hBEEF) begin n_fail++; $display("FAIL gap_alias_ram0 got=%h exp=not beef", inM); end
    addressM = 16'h0005; #1;
    n_checks++;
    if (inM !== 16'h1234) begin n_fail++; $display("FAIL ram_hold_5 got=%h exp=1234", inM); end
  endtask

  task automatic test_led();
    addressM = 16'h6002; outM = 16'h00FF; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (leds !== 16'h00FF) begin n_fail++; $display("FAIL led_port got=%h exp=00ff", leds); end
    n_checks++;
    if (inM !== 16'h00FF) begin n_fail++; $display("FAIL led_read got=%h exp=00ff", inM); end
  endtask

  task automatic test_kbd();
    addressM = 16'h6000; outM = 16'h7777; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0000 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL kbd_write_ignored got=%h/%b exp=0000/1", inM, key_ready);
    end
    key_data = 16'h0041; key_valid = 1'b1;
    cyc();
    key_data = 16'h0042; #1;
    n_checks++;
    if (key_ready !== 1'b0) begin n_fail++; $display("FAIL kbd_full_ready got=%b exp=0", key_ready); end
    n_checks++;
    if (inM !== 16'h0041) begin n_fail++; $display("FAIL kbd_capture got=%h exp=0041", inM); end
    cyc();
    n_checks++;
    if (inM !== 16'h0041) begin n_fail++; $display("FAIL kbd_hold_full got=%h exp=0041", inM); end
    addressM = 16'h6001; writeM = 1'b1; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL kbd_clr_read got=%h exp=0000", inM); end
    cyc();
    writeM = 1'b0; addressM = 16'h6000; #1;
    n_checks++;
    if (key_ready !== 1'b1 || inM !== 16'h0000) begin
      n_fail++; $display("FAIL kbd_cleared got=%b/%h exp=1/0000", key_ready, inM);
    end
    cyc();
    key_valid = 1'b0; #1;
    n_checks++;
    if (key_ready !== 1'b0 || inM !== 16'h0042) begin
      n_fail++; $display("FAIL kbd_second_key got=%b/%h exp=0/0042", key_ready, inM);
    end
    addressM = 16'h6001; writeM = 1'b1;
    cyc();
    writeM = 1'b0; addressM = 16'h6000; key_data = 16'h0000; key_valid = 1'b1;
    cyc();
    key_valid = 1'b0; #1;
    n_checks++;
    if (key_ready !== 1'b0 || inM !== 16'h0000) begin
      n_fail++; $display("FAIL kbd_zero_code got=%b/%h exp=0/0000", key_ready, inM);
    end
    addressM = 16'h6001; writeM = 1'b1;
    cyc();
    writeM = 1'b0; addressM = 16'h6001; outM = 16'h0000; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL kbd_clr_empty got=%b exp=1", key_ready); end
  endtask

  task automatic test_timer();
    addressM = 16'h6004; outM = 16'h0001; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0001) begin n_fail++; $display("FAIL ctrl_read got=%h exp=0001", inM); end
    addressM = 16'h6003;
    cyc(3);
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL timer_3cyc got=%h exp=0000", inM); end
    cyc();
    n_checks++;
    if (inM !== 16'h0001) begin n_fail++; $display("FAIL timer_4cyc got=%h exp=0001", inM); end
    cyc(8);
    n_checks++;
    if (inM !== 16'h0003) begin n_fail++; $display("FAIL timer_12cyc got=%h exp=0003", inM); end
    addressM = 16'h6004; outM = 16'h0000; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL ctrl_off got=%h exp=0000", inM); end
    addressM = 16'h6003;
    cyc(8);
    n_checks++;
    if (inM !== 16'h0003) begin n_fail++; $display("FAIL timer_hold got=%h exp=0003", inM); end
  endtask

  task automatic test_timer_wrap();
    addressM = 16'h6004; outM = 16'h0001; writeM = 1'b1;
    cyc();
    addressM = 16'h6003; outM = 16'hFFFF;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'hFFFF) begin n_fail++; $display("FAIL timer_load got=%h exp=ffff", inM); end
    cyc(3);
    n_checks++;
    if (inM !== 16'hFFFF) begin n_fail++; $display("FAIL timer_pre_wrap got=%h exp=ffff", inM); end
    cyc();
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL timer_wrap got=%h exp=0000", inM); end
    cyc(3);
    outM = 16'h0010; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0010) begin n_fail++; $display("FAIL timer_load_override got=%h exp=0010", inM); end
    cyc(3);
    n_checks++;
    if (inM !== 16'h0010) begin n_fail++; $display("FAIL timer_presc_cleared got=%h exp=0010", inM); end
    cyc();
    n_checks++;
    if (inM !== 16'h0011) begin n_fail++; $display("FAIL timer_after_load got=%h exp=0011", inM); end
  endtask

  task automatic test_mid_reset();
    addressM = 16'h6000; key_data = 16'h0055; key_valid = 1'b1;
    cyc();
    key_valid = 1'b0; addressM = 16'h6002; outM = 16'h00FF; writeM = 1'b1;
    cyc();
    writeM = 1'b0; #1;
    n_checks++;
    if (key_ready !== 1'b0 || leds !== 16'h00FF) begin
      n_fail++; $display("FAIL pre_reset_state got=%b/%h exp=0/00ff", key_ready, leds);
    end
    reset = 1'b1; addressM = 16'h0005; outM = 16'hDEAD; writeM = 1'b1;
    cyc();
    reset = 1'b0; writeM = 1'b0; #1;
    n_checks++;
    if (leds !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_leds got=%h exp=0000", leds); end
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=1", key_ready); end
    n_checks++;
    if (inM !== 16'h1234) begin n_fail++; $display("FAIL mid_reset_ram got=%h exp=1234", inM); end
    addressM = 16'h6004; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_en got=%h exp=0000", inM); end
    addressM = 16'h6000; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_kbd got=%h exp=0000", inM); end
    addressM = 16'h6003;
    cyc(5);
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_timer got=%h exp=0000", inM); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_kbd();
    test_timer();
    test_timer_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_data_bus_responder.md
Name: hack_data_bus_responder

Overview:
Data-memory side of the Hack CPU data bus: responds to the CPU's addressM/outM/writeM and returns inM. It contains the data RAM plus a small memory-mapped I/O page: a buffered keyboard register with a valid/ready input handshake, an LED output register and a prescaled free-running timer. The block sits between the CPU core and board I/O in the FPGA computer top level.

Parameters:
RAM_ADDR_W, 14, RAM address width; RAM depth is 2^RAM_ADDR_W words, mapped from 0x0000.
TIMER_DIV, 50, clk cycles per timer increment; legal range is 1..65535.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
addressM  in  16  CPU data address
outM  in  16  CPU write data
writeM  in  1  CPU write strobe; sampled on the rising edge of clk
inM  out  16  read data to the CPU, combinational from addressM
key_data  in  16  keyboard code from the input source
key_valid  in  1  key_data is valid
key_ready  out  1  key buffer empty; capture happens on key_valid && key_ready
leds  out  16  LED register value

Behaviour:
- Address map:
  - 0x0000 to (2^RAM_ADDR_W - 1): RAM, read/write.
  - 0x6000 KBD: read returns the buffered key code, or 0 when the buffer is empty. Writes are ignored.
  - 0x6001 KBD_CLR: a write of any value empties the buffer. Reads return 0.
  - 0x6002 LED: read/write.
  - 0x6003 TIMER: read returns the counter. A write loads the counter.
  - 0x6004 TIMER_CTRL: only bit0 (enable) is stored. Reads return {15'b0, en}.
  - All other addresses, including the region between RAM and 0x6000: reads return 0 and writes are ignored.
- Reads:
  - Zero-latency: inM is purely combinational from addressM and the current state.
  - RAM uses an asynchronous-read array, so the single-cycle CPU can consume the data in the same cycle.
- Writes:
  - A write takes effect on the rising edge where writeM=1.
  - Read-during-write to the same address: inM shows the old value in that cycle. The new value is visible from the next cycle.
- Reset (synchronous):
  - leds=0, timer=0, prescaler=0, en=0, key buffer empty, key_ready=1.
  - RAM contents are not reset.
  - Writes and key captures in the reset cycle are discarded.
- Keyboard buffer (one entry, states EMPTY/FULL):
  - key_ready = (state==EMPTY), registered.
  - EMPTY -> FULL on key_valid=1: latch key_data.
  - FULL -> EMPTY on a KBD_CLR write.
  - In FULL, key_valid is ignored. The source must hold key_valid until it is accepted.
  - KBD_CLR while EMPTY: no effect.
  - A clear and an arriving key in the same cycle: the clear wins, because key_ready=0 in that cycle. The key is captured on the first cycle after the buffer reads EMPTY.
  - A captured code of 0 still marks the buffer FULL. It reads as 0.
- Timer:
  - When en=1, the prescaler counts 0..TIMER_DIV-1.
  - On the cycle the prescaler is TIMER_DIV-1, it returns to 0 and the timer increments by 1. The timer is modulo 2^16: 0xFFFF wraps to 0x0000.
  - When en=0, both the prescaler and the timer hold.
  - A TIMER write loads outM and clears the prescaler. It overrides an increment in the same cycle.
  - A TIMER_CTRL write changes en from the next cycle. The prescaler is not cleared.
- Widths:
  - RAM index is addressM[RAM_ADDR_W-1:0], valid only when addressM < 2^RAM_ADDR_W.
  - The I/O decode compares the full 16-bit address.

Test Plan:
1. Reset, then read 0x6002, 0x6003, 0x6004, 0x6000 -> all 0; key_ready=1; leds=0.
2. Write 0x1234 to 0x0005, then read 0x0005 -> the write cycle shows the old value; the next cycle shows 0x1234. Write 0xBEEF to 0x4000 -> ignored; a read of 0x4000 returns 0.
3. Drive key_valid=1 with key_data=0x0041 -> one cycle later key_ready=0 and 0x6000 reads 0x0041. Change key_data to 0x0042 while FULL -> 0x6000 still reads 0x0041. Write 0x6001 -> buffer EMPTY, then 0x0042 is captured.
4. With TIMER_DIV=4, write 1 to 0x6004 -> the timer reads 1 after 4 enabled cycles and 3 after 12. Write 0x6004=0 -> the value holds.
5. Write 0xFFFF to 0x6003 with en=1 -> after TIMER_DIV cycles the timer reads 0x0000. Write 0x0010 on the cycle an increment is due -> the timer reads 0x0010, not 0x0011.
6. Mid-operation reset with the buffer FULL, timer running and leds=0x00FF -> after the reset edge: leds=0, timer=0, en=0, key_ready=1, and RAM word 0x0005 still reads 0x1234.
